// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scanner: segment table, blank
// pattern, bus widths and the scan-divider derivation.
package seg7_pkg;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned HEX_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SEG_W      = 8;
  localparam int unsigned NIBBLE_W   = 4;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is kept off in every entry.
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'hFF;

  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Clock cycles spent on each digit before moving to the next one.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Counter width able to hold 0..div-1 (at least one bit).
  function automatic int unsigned calc_div_w(input int unsigned div);
    return (div > 2) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to active-low seven-segment decoder.
// Ports:
//   nibble : hex value 0..F
//   blank  : force all segments off
//   seg_c  : active-low {dp,g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  input  logic                blank,
  output logic [SEG_W-1:0]    seg_c
);

  always_comb begin
    seg_c = SEG_TABLE[nibble];
    if (blank) begin
      seg_c = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg7_scan.sv
// Multiplexed 8-digit seven-segment scanner showing a 24-bit IO write value
// as six hex digits. Writes are staged and committed to a shadow register only
// at the end of a full scan frame so a frame never mixes old and new digits.
// Ports:
//   clock    : CPU clock, rising edge
//   reset    : asynchronous, active-high; clears all state
//   io_write : one-cycle IO write strobe
//   io_wdata : value to display, valid with io_write
//   seg_en   : active-low one-hot digit enables (registered)
//   seg_out  : active-low segments {dp,g,f,e,d,c,b,a} (registered)
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 23000000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned NUM_DIGITS  = 8,
  parameter bit          LZ_SUPPRESS = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_write,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [SEG_W-1:0]  seg_en,
  output logic [SEG_W-1:0]  seg_out
);

  localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, SCAN_HZ);
  localparam int unsigned DIV_W = calc_div_w(DIV);

  logic [DIV_W-1:0]  div_cnt;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] staged;
  logic [DATA_W-1:0] shadow;
  logic              pending;

  logic              tick_c;
  logic              frame_end_c;
  logic [DATA_W-1:0] shifted_c;
  logic              blank_c;
  logic [SEG_W-1:0]  seg_c;

  // Scan timing strobes.
  always_comb begin
    tick_c      = (div_cnt == DIV_W'(DIV - 1));
    frame_end_c = tick_c && (idx == IDX_W'(NUM_DIGITS - 1));
  end

  // Per-digit dwell counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Active digit index.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (tick_c) begin
      if (idx == IDX_W'(NUM_DIGITS - 1)) begin
        idx <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  // Write staging and frame-synchronous commit. A write landing on the
  // frame boundary bypasses staging so the older staged value is never shown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      staged  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else begin
      if (io_write) begin
        staged <= io_wdata;
      end
      if (frame_end_c) begin
        pending <= 1'b0;
        if (io_write) begin
          shadow <= io_wdata;
        end else if (pending) begin
          shadow <= staged;
        end
      end else if (io_write) begin
        pending <= 1'b1;
      end
    end
  end

  // Select the nibble for the active digit. The shifted word doubles as the
  // leading-zero test: everything at and above this digit is zero.
  always_comb begin
    shifted_c = shadow >> {idx, 2'b00};
    blank_c   = (idx >= IDX_W'(HEX_DIGITS)) ||
                (LZ_SUPPRESS && (idx != '0) && (shifted_c == '0));
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (shifted_c[NIBBLE_W-1:0]),
    .blank  (blank_c),
    .seg_c  (seg_c)
  );

  // Pin registers; both follow idx/shadow by one cycle so enable and
  // segment data always switch together.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg_en  <= SEG_BLANK;
      seg_out <= SEG_BLANK;
    end else begin
      seg_en  <= ~(SEG_W'(1) << idx);
      seg_out <= seg_c;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Self-checking bench for seg7_scan with DIV=4 (32-cycle frame). Two DUTs
// share stimulus: one plain, one with leading-zero suppression.
module tb_seg7_scan;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_write = 1'b0;
  logic [23:0] io_wdata = 24'h0;
  logic [7:0]  seg_en0, seg_out0, seg_en1, seg_out1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  seg7_scan #(.CLK_FREQ_HZ(8), .SCAN_HZ(2), .NUM_DIGITS(8), .LZ_SUPPRESS(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .io_write(io_write), .io_wdata(io_wdata),
    .seg_en(seg_en0), .seg_out(seg_out0));

  seg7_scan #(.CLK_FREQ_HZ(8), .SCAN_HZ(2), .NUM_DIGITS(8), .LZ_SUPPRESS(1'b1)) u_dut1 (
    .clock(clock), .reset(reset), .io_write(io_write), .io_wdata(io_wdata),
    .seg_en(seg_en1), .seg_out(seg_out1));

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  logic [7:0] tab_12abef [8] = '{8'h8E, 8'h86, 8'h83, 8'h88, 8'hA4, 8'hF9, 8'hFF, 8'hFF};
  logic [7:0] tab_5_lz0  [8] = '{8'h92, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF};
  logic [7:0] tab_5_lz1  [8] = '{8'h92, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  // Reference: what digit d of a displayed 24-bit value looks like.
  function automatic logic [7:0] ref_seg(input logic [23:0] s, input int d, input bit lz);
    logic [23:0] sh;
    sh = s >> (4 * d);
    if (d >= 6) return 8'hFF;
    if (lz && d != 0 && sh == 24'h0) return 8'hFF;
    return seg_tbl[sh[3:0]];
  endfunction

  // Reference model: a frame is 32 cycles, 4 per digit; the last value written
  // during a frame (boundary cycle included) is what the next frame shows.
  int          pos = 0;
  logic [23:0] m_shown = 24'h0;
  logic [23:0] m_last = 24'h0;
  bit          m_have = 1'b0;
  logic [7:0]  exp_en = 8'hFF, exp_seg0 = 8'hFF, exp_seg1 = 8'hFF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pos <= 0; m_shown <= 24'h0; m_last <= 24'h0; m_have <= 1'b0;
      exp_en <= 8'hFF; exp_seg0 <= 8'hFF; exp_seg1 <= 8'hFF;
    end else begin
      exp_en   <= ~(8'h01 << (pos / 4));
      exp_seg0 <= ref_seg(m_shown, pos / 4, 1'b0);
      exp_seg1 <= ref_seg(m_shown, pos / 4, 1'b1);
      if (pos == 31) begin
        m_have <= 1'b0;
        if (io_write) m_shown <= io_wdata;
        else if (m_have) m_shown <= m_last;
      end else if (io_write) begin
        m_last <= io_wdata;
        m_have <= 1'b1;
      end
      pos <= (pos + 1) % 32;
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    io_write = 1'b0;
    while (pos != p && n < 64) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (pos != p) begin
      errors++;
      $display("FAIL wait_pos got %0d want %0d", pos, p);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (seg_en0 !== 8'hFF || seg_out0 !== 8'hFF || seg_en1 !== 8'hFF || seg_out1 !== 8'hFF) begin
      errors++;
      $display("FAIL reset_pins got %h/%h %h/%h want FF/FF", seg_en0, seg_out0, seg_en1, seg_out1);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 36; k++) begin
      int dd;
      logic [7:0] want_en, want_seg;
      @(negedge clock);
      dd = (k / 4) % 8;
      want_en = ~(8'h01 << dd);
      want_seg = (dd < 6) ? 8'hC0 : 8'hFF;
      checks++;
      if (seg_en0 !== want_en || seg_en1 !== want_en) begin
        errors++;
        $display("FAIL rotate_en k=%0d got %h %h want %h", k, seg_en0, seg_en1, want_en);
      end
      checks++;
      if (seg_out0 !== want_seg || seg_out1 !== ((dd == 0) ? 8'hC0 : 8'hFF)) begin
        errors++;
        $display("FAIL zero_digits k=%0d got %h %h want %h", k, seg_out0, seg_out1, want_seg);
      end
    end
  endtask

  task automatic test_write_mid_frame();
    wait_pos(10);
    io_write = 1'b1;
    io_wdata = 24'h12ABEF;
    @(negedge clock);
    io_write = 1'b0;
    for (int k = 0; k < 21; k++) begin
      int dd;
      @(negedge clock);
      dd = ((pos + 31) % 32) / 4;
      checks++;
      if (seg_out0 !== ((dd < 6) ? 8'hC0 : 8'hFF)) begin
        errors++;
        $display("FAIL mid_hold dd=%0d got %h want %h", dd, seg_out0, (dd < 6) ? 8'hC0 : 8'hFF);
      end
    end
    for (int k = 0; k < 32; k++) begin
      int dd;
      @(negedge clock);
      dd = ((pos + 31) % 32) / 4;
      checks++;
      if (seg_out0 !== tab_12abef[dd] || seg_out1 !== tab_12abef[dd] || seg_en0 !== exp_en) begin
        errors++;
        $display("FAIL mid_commit dd=%0d got %h %h want %h", dd, seg_out0, seg_out1, tab_12abef[dd]);
      end
    end
  endtask

  task automatic test_coincident();
    wait_pos(31);
    io_write = 1'b1;
    io_wdata = 24'h000005;
    @(negedge clock);
    io_write = 1'b0;
    for (int k = 0; k < 32; k++) begin
      int dd;
      @(negedge clock);
      dd = ((pos + 31) % 32) / 4;
      checks++;
      if (seg_out1 !== tab_5_lz1[dd]) begin
        errors++;
        $display("FAIL coinc_lz dd=%0d got %h want %h", dd, seg_out1, tab_5_lz1[dd]);
      end
      checks++;
      if (seg_out0 !== tab_5_lz0[dd]) begin
        errors++;
        $display("FAIL coinc_plain dd=%0d got %h want %h", dd, seg_out0, tab_5_lz0[dd]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wait_pos(3);
    io_write = 1'b1;
    io_wdata = 24'h111111;
    @(negedge clock);
    io_wdata = 24'h222222;
    @(negedge clock);
    io_write = 1'b0;
    for (int k = 0; k < 59; k++) begin
      int dd;
      @(negedge clock);
      dd = ((pos + 31) % 32) / 4;
      checks++;
      if (seg_out0 === 8'hF9 || seg_out0 !== exp_seg0) begin
        errors++;
        $display("FAIL b2b k=%0d got %h want %h", k, seg_out0, exp_seg0);
      end
      if (k >= 27) begin
        checks++;
        if (seg_out0 !== ((dd < 6) ? 8'hA4 : 8'hFF) || seg_out1 !== seg_out0) begin
          errors++;
          $display("FAIL b2b_last dd=%0d got %h %h want %h", dd, seg_out0, seg_out1, (dd < 6) ? 8'hA4 : 8'hFF);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    wait_pos(8);
    io_write = 1'b1;
    io_wdata = 24'h0ABCDE;
    @(negedge clock);
    io_write = 1'b0;
    wait_pos(15);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (seg_en0 !== 8'hFF || seg_out0 !== 8'hFF || seg_en1 !== 8'hFF || seg_out1 !== 8'hFF) begin
      errors++;
      $display("FAIL reset_mid_async got %h/%h %h/%h want FF/FF", seg_en0, seg_out0, seg_en1, seg_out1);
    end
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      int dd;
      @(negedge clock);
      dd = (k / 4) % 8;
      checks++;
      if (seg_en0 !== ~(8'h01 << dd) || seg_out0 !== ((dd < 6) ? 8'hC0 : 8'hFF) ||
          seg_out1 !== ((dd == 0) ? 8'hC0 : 8'hFF)) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d got %h %h %h", k, seg_en0, seg_out0, seg_out1);
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 320; cyc++) begin
      @(negedge clock);
      checks++;
      if (seg_en0 !== exp_en || seg_en1 !== exp_en) begin
        errors++;
        $display("FAIL rand_en cyc %0d got %h %h want %h", cyc, seg_en0, seg_en1, exp_en);
      end
      checks++;
      if (seg_out0 !== exp_seg0 || seg_out1 !== exp_seg1) begin
        errors++;
        $display("FAIL rand_seg cyc %0d got %h %h want %h %h", cyc, seg_out0, seg_out1, exp_seg0, exp_seg1);
      end
      checks++;
      if ($countones(seg_en0) != 7) begin
        errors++;
        $display("FAIL rand_onehot cyc %0d got %h want one low bit", cyc, seg_en0);
      end
      io_write = ($urandom_range(0, 3) == 0);
      io_wdata = 24'($urandom());
      if ($urandom_range(0, 1) == 1) io_wdata = io_wdata >> (4 * $urandom_range(0, 6));
    end
    io_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_mid_frame();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
